bellek_islem_denetleyici: RTL and testbench



---
 rtl/bellek_islem_denetleyici.sv | 186 ++++++++++++++++++
 tb/tb_bellek_islem_denetleyici.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_islem_denetleyici.sv
// Load/store sequencer between the memory stage and the L1 data cache port.
// Latches one micro-op, checks alignment, runs the L1 handshake and formats the result.
package bellek_islem_pkg;
   localparam int VERI_BIT    = 32;
   localparam int ADRES_BIT   = 32;
   localparam int PS_BIT      = 32;
   localparam int UOP_BEL_BIT = 4;

   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_NOP = 4'd0;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_LW  = 4'd1;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_LH  = 4'd2;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_LHU = 4'd3;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_LB  = 4'd4;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_LBU = 4'd5;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_SW  = 4'd6;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_SH  = 4'd7;
   localparam logic [UOP_BEL_BIT-1:0] UOP_BEL_SB  = 4'd8;
endpackage

module bellek_islem_denetleyici
   import bellek_islem_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   islem_gecerli_i,
   output logic                   islem_hazir_o,
   input  logic [UOP_BEL_BIT-1:0] uop_bel_i,
   input  logic [ADRES_BIT-1:0]   adres_i,
   input  logic [VERI_BIT-1:0]    yazilacak_veri_i,
   output logic                   sonuc_gecerli_o,
   output logic [VERI_BIT-1:0]    sonuc_veri_o,
   output logic                   hizasiz_o,
   output logic                   l1v_istek_gecerli_o,
   input  logic                   l1v_istek_hazir_i,
   output logic [PS_BIT-1:0]      l1v_istek_adres_o,
   output logic                   l1v_istek_yaz_o,
   output logic [VERI_BIT-1:0]    l1v_istek_veri_o,
   output logic [3:0]             l1v_istek_maske_o,
   input  logic [VERI_BIT-1:0]    l1v_veri_i,
   input  logic                   l1v_veri_gecerli_i,
   output logic                   l1v_veri_hazir_o
);

   typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, SONUC} durum_t;

   durum_t                 durum_reg, durum_next;
   logic [UOP_BEL_BIT-1:0] uop_reg, uop_next;
   logic [ADRES_BIT-1:0]   adres_reg, adres_next;
   logic [VERI_BIT-1:0]    veri_reg, veri_next;
   logic [VERI_BIT-1:0]    sonuc_veri_reg, sonuc_veri_next;
   logic                   hizasiz_reg, hizasiz_next;

   logic [VERI_BIT-1:0]    sb_veri, sh_veri, kaydirilmis, bicimli;
   logic                   yazma_mi;

   function automatic logic hizasiz_hesapla(input logic [UOP_BEL_BIT-1:0] uop,
                                            input logic [1:0] alt);
      case (uop)
         UOP_BEL_LW, UOP_BEL_SW:              return (alt != 2'b00);
         UOP_BEL_LH, UOP_BEL_LHU, UOP_BEL_SH: return alt[0];
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic bellek_kodu_mu(input logic [UOP_BEL_BIT-1:0] uop);
      return (uop >= UOP_BEL_LW) && (uop <= UOP_BEL_SB);
   endfunction

   // Byte lanes replicate rs2 so the cache only has to honour the mask.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_serit
         assign sb_veri[8*gi +: 8] = veri_reg[7:0];
         assign sh_veri[8*gi +: 8] = veri_reg[8*(gi % 2) +: 8];
      end
   endgenerate

   assign yazma_mi = (uop_reg == UOP_BEL_SW) || (uop_reg == UOP_BEL_SH) ||
                     (uop_reg == UOP_BEL_SB);

   // Request fields come only from latched registers, so they stay stable while stalled.
   always_comb begin
      l1v_istek_adres_o = {adres_reg[PS_BIT-1:2], 2'b00};
      l1v_istek_yaz_o   = yazma_mi;
      l1v_istek_maske_o = 4'b0000;
      l1v_istek_veri_o  = '0;
      case (uop_reg)
         UOP_BEL_SW: begin
            l1v_istek_maske_o = 4'b1111;
            l1v_istek_veri_o  = veri_reg;
         end
         UOP_BEL_SH: begin
            l1v_istek_maske_o = 4'b0011 << {adres_reg[1], 1'b0};
            l1v_istek_veri_o  = sh_veri;
         end
         UOP_BEL_SB: begin
            l1v_istek_maske_o = 4'b0001 << adres_reg[1:0];
            l1v_istek_veri_o  = sb_veri;
         end
         default: ;
      endcase
   end

   assign kaydirilmis = l1v_veri_i >> {adres_reg[1:0], 3'b000};

   always_comb begin
      bicimli = '0;
      case (uop_reg)
         UOP_BEL_LW:  bicimli = kaydirilmis;
         UOP_BEL_LH:  bicimli = {{16{kaydirilmis[15]}}, kaydirilmis[15:0]};
         UOP_BEL_LHU: bicimli = {16'h0000, kaydirilmis[15:0]};
         UOP_BEL_LB:  bicimli = {{24{kaydirilmis[7]}}, kaydirilmis[7:0]};
         UOP_BEL_LBU: bicimli = {24'h000000, kaydirilmis[7:0]};
         default:     bicimli = '0;
      endcase
   end

   always_comb begin
      durum_next          = durum_reg;
      uop_next            = uop_reg;
      adres_next          = adres_reg;
      veri_next           = veri_reg;
      sonuc_veri_next     = sonuc_veri_reg;
      hizasiz_next        = hizasiz_reg;
      islem_hazir_o       = 1'b0;
      l1v_istek_gecerli_o = 1'b0;
      l1v_veri_hazir_o    = 1'b0;
      sonuc_gecerli_o     = 1'b0;
      sonuc_veri_o        = '0;
      hizasiz_o           = 1'b0;
      case (durum_reg)
         BOSTA: begin
            islem_hazir_o = !rst_i;
            if (islem_gecerli_i) begin
               uop_next        = uop_bel_i;
               adres_next      = adres_i;
               veri_next       = yazilacak_veri_i;
               sonuc_veri_next = '0;
               hizasiz_next    = hizasiz_hesapla(uop_bel_i, adres_i[1:0]);
               if (hizasiz_hesapla(uop_bel_i, adres_i[1:0]) || !bellek_kodu_mu(uop_bel_i))
                  durum_next = SONUC;
               else
                  durum_next = ISTEK;
            end
         end
         ISTEK: begin
            l1v_istek_gecerli_o = 1'b1;
            if (l1v_istek_hazir_i)
               durum_next = yazma_mi ? SONUC : BEKLE;
         end
         BEKLE: begin
            l1v_veri_hazir_o = 1'b1;
            if (l1v_veri_gecerli_i) begin
               sonuc_veri_next = bicimli;
               durum_next      = SONUC;
            end
         end
         SONUC: begin
            sonuc_gecerli_o = 1'b1;
            sonuc_veri_o    = sonuc_veri_reg;
            hizasiz_o       = hizasiz_reg;
            durum_next      = BOSTA;
         end
         default: durum_next = BOSTA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_reg      <= BOSTA;
         uop_reg        <= '0;
         adres_reg      <= '0;
         veri_reg       <= '0;
         sonuc_veri_reg <= '0;
         hizasiz_reg    <= 1'b0;
      end else begin
         durum_reg      <= durum_next;
         uop_reg        <= uop_next;
         adres_reg      <= adres_next;
         veri_reg       <= veri_next;
         sonuc_veri_reg <= sonuc_veri_next;
         hizasiz_reg    <= hizasiz_next;
      end
   end

endmodule

// File: tb/tb_bellek_islem_denetleyici.sv
// Directed bench for bellek_islem_denetleyici: hand-computed vectors, outputs
// sampled on the falling edge while the DUT updates on the rising edge.
module tb_bellek_islem_denetleyici;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        islem_gecerli_i;
   logic        islem_hazir_o;
   logic [3:0]  uop_bel_i;
   logic [31:0] adres_i;
   logic [31:0] yazilacak_veri_i;
   logic        sonuc_gecerli_o;
   logic [31:0] sonuc_veri_o;
   logic        hizasiz_o;
   logic        l1v_istek_gecerli_o;
   logic        l1v_istek_hazir_i;
   logic [31:0] l1v_istek_adres_o;
   logic        l1v_istek_yaz_o;
   logic [31:0] l1v_istek_veri_o;
   logic [3:0]  l1v_istek_maske_o;
   logic [31:0] l1v_veri_i;
   logic        l1v_veri_gecerli_i;
   logic        l1v_veri_hazir_o;

   localparam logic [3:0] NOP = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                          SW = 4'd6, SH = 4'd7, SB = 4'd8;

   int dogrulama_sayisi = 0;
   int hata_sayisi      = 0;

   always #5 clk_i = ~clk_i;

   bellek_islem_denetleyici dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .islem_gecerli_i     (islem_gecerli_i),
      .islem_hazir_o       (islem_hazir_o),
      .uop_bel_i           (uop_bel_i),
      .adres_i             (adres_i),
      .yazilacak_veri_i    (yazilacak_veri_i),
      .sonuc_gecerli_o     (sonuc_gecerli_o),
      .sonuc_veri_o        (sonuc_veri_o),
      .hizasiz_o           (hizasiz_o),
      .l1v_istek_gecerli_o (l1v_istek_gecerli_o),
      .l1v_istek_hazir_i   (l1v_istek_hazir_i),
      .l1v_istek_adres_o   (l1v_istek_adres_o),
      .l1v_istek_yaz_o     (l1v_istek_yaz_o),
      .l1v_istek_veri_o    (l1v_istek_veri_o),
      .l1v_istek_maske_o   (l1v_istek_maske_o),
      .l1v_veri_i          (l1v_veri_i),
      .l1v_veri_gecerli_i  (l1v_veri_gecerli_i),
      .l1v_veri_hazir_o    (l1v_veri_hazir_o)
   );

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      dogrulama_sayisi++;
      if (gozlenen !== beklenen) begin
         hata_sayisi++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic adim();
      @(negedge clk_i);
   endtask

   // Present an op for one cycle; it is accepted on the next rising edge.
   task automatic islem_ver(input logic [3:0] uop, input logic [31:0] adr,
                            input logic [31:0] rs2);
      islem_gecerli_i  = 1'b1;
      uop_bel_i        = uop;
      adres_i          = adr;
      yazilacak_veri_i = rs2;
      adim();
      islem_gecerli_i  = 1'b0;
   endtask

   task automatic bosta_kontrol(input string etiket);
      kontrol({etiket, "_hazir"}, 32'(islem_hazir_o), 32'd1);
      kontrol({etiket, "_sonuc0"}, 32'(sonuc_gecerli_o), 32'd0);
      kontrol({etiket, "_veri0"}, sonuc_veri_o, 32'h0);
   endtask

   initial begin
      rst_i = 1'b1;
      islem_gecerli_i = 1'b0;
      uop_bel_i = NOP;
      adres_i = '0;
      yazilacak_veri_i = '0;
      l1v_istek_hazir_i = 1'b0;
      l1v_veri_i = '0;
      l1v_veri_gecerli_i = 1'b0;

      // Reset state
      repeat (3) adim();
      kontrol("rst_hazir", 32'(islem_hazir_o), 32'd0);
      kontrol("rst_sonuc", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rst_istek", 32'(l1v_istek_gecerli_o), 32'd0);
      kontrol("rst_maske", 32'(l1v_istek_maske_o), 32'd0);
      kontrol("rst_adres", l1v_istek_adres_o, 32'h0);
      kontrol("rst_vhazir", 32'(l1v_veri_hazir_o), 32'd0);
      rst_i = 1'b0;
      #1;
      kontrol("rst_sonra_hazir", 32'(islem_hazir_o), 32'd1);

      // LB 0x1003, zero-wait L1
      islem_ver(LB, 32'h0000_1003, 32'h0);
      kontrol("lb_istek", 32'(l1v_istek_gecerli_o), 32'd1);
      kontrol("lb_adres", l1v_istek_adres_o, 32'h0000_1000);
      kontrol("lb_maske", 32'(l1v_istek_maske_o), 32'h0);
      kontrol("lb_yaz", 32'(l1v_istek_yaz_o), 32'd0);
      kontrol("lb_hazir_dustu", 32'(islem_hazir_o), 32'd0);
      l1v_istek_hazir_i = 1'b1;
      adim();
      kontrol("lb_vhazir", 32'(l1v_veri_hazir_o), 32'd1);
      kontrol("lb_istek_bitti", 32'(l1v_istek_gecerli_o), 32'd0);
      l1v_istek_hazir_i = 1'b0;
      l1v_veri_i = 32'h80FF_0000;
      l1v_veri_gecerli_i = 1'b1;
      adim();
      l1v_veri_gecerli_i = 1'b0;
      kontrol("lb_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("lb_veri", sonuc_veri_o, 32'hFFFF_FF80);
      kontrol("lb_hizasiz", 32'(hizasiz_o), 32'd0);
      $display("islem LB  adres=0x00001003 sonuc=0x%08h", sonuc_veri_o);
      adim();
      bosta_kontrol("lb_son");

      // LHU 0x2002, request stalled 3 cycles, data 2 cycles
      islem_ver(LHU, 32'h0000_2002, 32'h0);
      for (int i = 0; i < 3; i++) begin
         kontrol("lhu_istek_bekle", 32'(l1v_istek_gecerli_o), 32'd1);
         kontrol("lhu_adres_sabit", l1v_istek_adres_o, 32'h0000_2000);
         kontrol("lhu_maske_sabit", 32'(l1v_istek_maske_o), 32'h0);
         adim();
      end
      kontrol("lhu_istek_son", 32'(l1v_istek_gecerli_o), 32'd1);
      l1v_istek_hazir_i = 1'b1;
      adim();
      l1v_istek_hazir_i = 1'b0;
      l1v_veri_i = 32'hBEEF_1234;
      for (int i = 0; i < 2; i++) begin
         kontrol("lhu_vhazir", 32'(l1v_veri_hazir_o), 32'd1);
         kontrol("lhu_sonuc_erken", 32'(sonuc_gecerli_o), 32'd0);
         adim();
      end
      l1v_veri_gecerli_i = 1'b1;
      adim();
      l1v_veri_gecerli_i = 1'b0;
      kontrol("lhu_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("lhu_veri", sonuc_veri_o, 32'h0000_BEEF);
      $display("islem LHU adres=0x00002002 sonuc=0x%08h", sonuc_veri_o);
      adim();
      bosta_kontrol("lhu_son");

      // SB 0x3001
      islem_ver(SB, 32'h0000_3001, 32'h0000_00AB);
      kontrol("sb_maske", 32'(l1v_istek_maske_o), 32'b0010);
      kontrol("sb_veri", l1v_istek_veri_o, 32'hABAB_ABAB);
      kontrol("sb_yaz", 32'(l1v_istek_yaz_o), 32'd1);
      kontrol("sb_adres", l1v_istek_adres_o, 32'h0000_3000);
      l1v_istek_hazir_i = 1'b1;
      adim();
      l1v_istek_hazir_i = 1'b0;
      kontrol("sb_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("sb_sonuc_veri", sonuc_veri_o, 32'h0);
      kontrol("sb_hizasiz", 32'(hizasiz_o), 32'd0);
      kontrol("sb_vhazir", 32'(l1v_veri_hazir_o), 32'd0);
      $display("islem SB  adres=0x00003001 maske=0010");
      adim();
      bosta_kontrol("sb_son");

      // Misaligned SW 0x4002 and LH 0x4001
      islem_ver(SW, 32'h0000_4002, 32'h1111_2222);
      kontrol("sw_hiz_istek", 32'(l1v_istek_gecerli_o), 32'd0);
      kontrol("sw_hiz_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("sw_hiz_hizasiz", 32'(hizasiz_o), 32'd1);
      kontrol("sw_hiz_veri", sonuc_veri_o, 32'h0);
      $display("islem SW  adres=0x00004002 hizasiz=%0d", hizasiz_o);
      adim();
      kontrol("sw_hiz_son_hizasiz", 32'(hizasiz_o), 32'd0);
      islem_ver(LH, 32'h0000_4001, 32'h0);
      kontrol("lh_hiz_istek", 32'(l1v_istek_gecerli_o), 32'd0);
      kontrol("lh_hiz_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("lh_hiz_hizasiz", 32'(hizasiz_o), 32'd1);
      $display("islem LH  adres=0x00004001 hizasiz=%0d", hizasiz_o);
      adim();

      // NOP completes at t1 without error
      islem_ver(NOP, 32'h0000_5000, 32'h0);
      kontrol("nop_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("nop_hizasiz", 32'(hizasiz_o), 32'd0);
      kontrol("nop_istek", 32'(l1v_istek_gecerli_o), 32'd0);
      $display("islem NOP");
      adim();

      // Reset while waiting for load data, then late data
      islem_ver(LW, 32'h0000_6000, 32'h0);
      l1v_istek_hazir_i = 1'b1;
      adim();
      l1v_istek_hazir_i = 1'b0;
      kontrol("rstb_bekle", 32'(l1v_veri_hazir_o), 32'd1);
      rst_i = 1'b1;
      adim();
      kontrol("rstb_sonuc", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rstb_hazir_rst", 32'(islem_hazir_o), 32'd0);
      rst_i = 1'b0;
      l1v_veri_i = 32'hDEAD_BEEF;
      l1v_veri_gecerli_i = 1'b1;
      #1;
      kontrol("rstb_hazir", 32'(islem_hazir_o), 32'd1);
      adim();
      kontrol("rstb_gec_sonuc", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rstb_gec_vhazir", 32'(l1v_veri_hazir_o), 32'd0);
      kontrol("rstb_gec_hazir", 32'(islem_hazir_o), 32'd1);
      l1v_veri_gecerli_i = 1'b0;
      $display("islem LW  adres=0x00006000 reset ile iptal");
      adim();

      // Back-to-back SH 0x10 then LW 0x14 with islem_gecerli_i held high
      islem_gecerli_i  = 1'b1;
      uop_bel_i        = SH;
      adres_i          = 32'h0000_0010;
      yazilacak_veri_i = 32'h1234_ABCD;
      adim();
      uop_bel_i        = LW;
      adres_i          = 32'h0000_0014;
      yazilacak_veri_i = 32'h0;
      kontrol("sh_maske", 32'(l1v_istek_maske_o), 32'b0011);
      kontrol("sh_veri", l1v_istek_veri_o, 32'hABCD_ABCD);
      kontrol("sh_yaz", 32'(l1v_istek_yaz_o), 32'd1);
      kontrol("sh_hazir_dusuk", 32'(islem_hazir_o), 32'd0);
      l1v_istek_hazir_i = 1'b1;
      adim();
      l1v_istek_hazir_i = 1'b0;
      kontrol("sh_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("sh_sonuc_hazir", 32'(islem_hazir_o), 32'd0);
      $display("islem SH  adres=0x00000010 maske=0011");
      adim();
      kontrol("lw2_bosta_hazir", 32'(islem_hazir_o), 32'd1);
      kontrol("lw2_bosta_istek", 32'(l1v_istek_gecerli_o), 32'd0);
      adim();
      islem_gecerli_i = 1'b0;
      kontrol("lw2_istek", 32'(l1v_istek_gecerli_o), 32'd1);
      kontrol("lw2_adres", l1v_istek_adres_o, 32'h0000_0014);
      kontrol("lw2_maske", 32'(l1v_istek_maske_o), 32'h0);
      kontrol("lw2_yaz", 32'(l1v_istek_yaz_o), 32'd0);
      l1v_istek_hazir_i = 1'b1;
      adim();
      l1v_istek_hazir_i = 1'b0;
      l1v_veri_i = 32'hCAFE_BABE;
      l1v_veri_gecerli_i = 1'b1;
      adim();
      l1v_veri_gecerli_i = 1'b0;
      kontrol("lw2_sonuc", 32'(sonuc_gecerli_o), 32'd1);
      kontrol("lw2_veri", sonuc_veri_o, 32'hCAFE_BABE);
      $display("islem LW  adres=0x00000014 sonuc=0x%08h", sonuc_veri_o);
      adim();
      bosta_kontrol("lw2_son");

      $display("End of test - %0d assertions evaluated, %0d failures",
               dogrulama_sayisi, hata_sayisi);
      $finish;
   end

endmodule
